// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and baud divisor helper.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned freq_hz,
                                                 input int unsigned baud);
        return freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous inputs; both flops reset to 1 (idle-high lines).
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with single-byte valid/ready holding register and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and add the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    input  logic       clr_err
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic rxs;

    uart_sync2 u_sync (
        .clk   (CLK),
        .rst_n (RESET),
        .d     (RXD),
        .q     (rxs)
    );

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver_q, deliver_d;
    logic                 frame_set;
    logic                 cnt_zero;
`ifdef UART_RX_PARITY_EN
    logic                 parity_set;
    logic                 parity_err_q;
`endif

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            deliver_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            deliver_q <= deliver_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = FULL_LOAD;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL_LOAD;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    parity_set = (^shift_q) ^ rxs;
                    state_d    = STOP;
                    cnt_d      = FULL_LOAD;
                end
            end
`endif
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    deliver_d = 1'b1;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line produces one frame only; wait for idle before rearming.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       overrun_q;
    logic       frame_err_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (deliver_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (deliver_q && rx_valid_q && !rx_ready) begin
                overrun_q <= 1'b1;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end
            if (frame_set) begin
                frame_err_q <= 1'b1;
            end else if (clr_err) begin
                frame_err_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            parity_err_q <= 1'b0;
        end else if (parity_set) begin
            parity_err_q <= 1'b1;
        end else if (clr_err) begin
            parity_err_q <= 1'b0;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a byte scoreboard.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PBITS = 1;
`else
    localparam int unsigned PBITS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       overrun;
    logic       frame_err;
    logic       clr_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ_HZ (16),
        .BAUD_RATE   (1)
    ) dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .RXD       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .clr_err   (clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_pop(input string tag);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            chk(tag, {24'd0, rx_data}, {24'd0, exp});
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!rx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    endtask

    // Inputs change on negedges; a frame starts with the start bit driven before edge 0.
    task automatic send_frame(input logic [7:0] b, input bit chk_lat, input bit ready_pulse);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = ^b;
        repeat (CPB) @(negedge clk);
`endif
        rxd = 1'b1;
        for (int k = 0; k < CPB; k++) begin
            if (k == 11) begin
                if (chk_lat) chk("lat_before", {31'd0, rx_valid}, 32'd0);
                if (ready_pulse) rx_ready = 1'b1;
            end
            if (k == 12) begin
                if (chk_lat) chk("lat_at", {31'd0, rx_valid}, 32'd1);
                rx_ready = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        int deliveries;

        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte, exact latency, handshake clear.
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_valid("a5", 50);
        chk_pop("a5_data");
        chk("a5_ferr", {31'd0, frame_err}, 32'd0);
        chk("a5_ovr", {31'd0, overrun}, 32'd0);
`ifdef UART_RX_PARITY_EN
        chk("a5_perr", {31'd0, parity_err}, 32'd0);
`endif
        consume();
        chk("a5_cleared", {31'd0, rx_valid}, 32'd0);

        // Back-to-back frames without reading: second one is dropped.
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0);
        wait_valid("ovr", 50);
        chk_pop("ovr_data");
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        pulse_clr();
        chk("ovr_clr", {31'd0, overrun}, 32'd0);
        chk("ovr_keep_data", {24'd0, rx_data}, 32'h3C);
        consume();
        chk("ovr_drained", {31'd0, rx_valid}, 32'd0);

        // Short low glitch must be rejected at mid start bit.
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
        chk("glitch_ferr", {31'd0, frame_err}, 32'd0);
        chk("glitch_ovr", {31'd0, overrun}, 32'd0);

        // Stuck-low line: exactly one 0x00 with framing error.
        sb.push_back(8'h00);
        deliveries = 0;
        rxd = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (rx_valid && !rx_ready) begin
                deliveries++;
                chk_pop("brk_data");
                chk("brk_ferr", {31'd0, frame_err}, 32'd1);
                rx_ready = 1'b1;
            end else begin
                rx_ready = 1'b0;
            end
            @(negedge clk);
        end
        rx_ready = 1'b0;
        rxd = 1'b1;
        for (int c = 0; c < 3 * CPB; c++) begin
            if (rx_valid && !rx_ready) begin
                deliveries++;
                rx_ready = 1'b1;
            end else begin
                rx_ready = 1'b0;
            end
            @(negedge clk);
        end
        rx_ready = 1'b0;
        chk("brk_count", deliveries, 32'd1);
        chk("brk_ovr", {31'd0, overrun}, 32'd0);
        pulse_clr();
        chk("brk_ferr_clr", {31'd0, frame_err}, 32'd0);

        // Unread 0x12, then 0x55 accepted with ready in the delivery cycle.
        sb.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b0);
        wait_valid("b12", 50);
        chk_pop("b12_data");
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b0, 1'b1);
        chk("b55_valid", {31'd0, rx_valid}, 32'd1);
        chk_pop("b55_data");
        chk("b55_ovr", {31'd0, overrun}, 32'd0);

        // Reset in the middle of data bit 3 of 0xFF.
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_valid("b81", 50);
        chk_pop("b81_data");
        chk("b81_ferr", {31'd0, frame_err}, 32'd0);
        chk("b81_ovr", {31'd0, overrun}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
